// File: rtl/bridge_pkg.sv
// Shared types for the drawbridge plant model and its controller.
// Motion encoding, controller state codes, sensor bit order {CIB,MD,PB,BS,H,L}.
package bridge_pkg;

  localparam int TRAVEL_TICKS_DEF = 16;
  localparam int POS_W_DEF        = 5;
  localparam int CAR_W_DEF        = 4;

  typedef enum logic [1:0] {
    AT_LOW   = 2'b00,
    RAISING  = 2'b01,
    AT_HIGH  = 2'b10,
    LOWERING = 2'b11
  } motion_t;

  typedef enum logic [1:0] {
    CTRL_FLAT     = 2'b00,
    CTRL_LIFTING  = 2'b01,
    CTRL_UPRIGHT  = 2'b10,
    CTRL_LOWERING = 2'b11
  } ctrl_state_t;

  localparam int SENS_L   = 0;
  localparam int SENS_H   = 1;
  localparam int SENS_BS  = 2;
  localparam int SENS_PB  = 3;
  localparam int SENS_MD  = 4;
  localparam int SENS_CIB = 5;
  localparam int SENS_W   = 6;

  function automatic logic [SENS_W-1:0] pack_sensors(input logic cib, input logic md,
                                                     input logic pb, input logic bs,
                                                     input logic h, input logic l);
    return {cib, md, pb, bs, h, l};
  endfunction

endpackage

// File: rtl/bridge_plant_model_if.sv
// Bundle between controller/stimulus (master) and the plant model (slave).
// Inputs are single-cycle sampled levels/pulses; outputs are registered or register-decoded.
interface bridge_plant_model_if #(
  parameter int POS_W = bridge_pkg::POS_W_DEF,
  parameter int CAR_W = bridge_pkg::CAR_W_DEF
) ();
  logic             MT;
  logic             AL;
  logic             TFL;
  logic             car_enter;
  logic             car_exit;
  logic             boat_arrive;
  logic             boat_clear;
  logic             jam_inject;
  logic             CIB;
  logic             BS;
  logic             H;
  logic             L;
  logic [POS_W-1:0] pos;
  logic             fault;
  logic             viol;
  logic             jammed;
  logic [CAR_W-1:0] car_cnt;
  bridge_pkg::motion_t state;

  modport master (
    output MT, AL, TFL, car_enter, car_exit, boat_arrive, boat_clear, jam_inject,
    input  CIB, BS, H, L, pos, fault, viol, jammed, car_cnt, state
  );

  modport slave (
    input  MT, AL, TFL, car_enter, car_exit, boat_arrive, boat_clear, jam_inject,
    output CIB, BS, H, L, pos, fault, viol, jammed, car_cnt, state
  );
endinterface

// File: rtl/bridge_car_counter.sv
// Deck occupancy counter: accepts cars only on green with the deck flat, flags illegal entries.
module bridge_car_counter #(
  parameter int CAR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             car_enter,
  input  logic             car_exit,
  input  logic             tfl,
  input  logic             low,
  output logic [CAR_W-1:0] cnt,
  output logic             cib,
  output logic             viol
);
  localparam logic [CAR_W-1:0] CNT_MAX = '1;

  logic accept, leave, illegal;

  // A full deck silently drops the entry; only red light or raised deck counts as a violation.
  assign accept  = car_enter & ~tfl & low & (cnt != CNT_MAX);
  assign illegal = car_enter & (tfl | ~low);
  assign leave   = car_exit & (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      viol <= 1'b0;
    end else begin
      if (accept && !leave)      cnt <= cnt + CAR_W'(1);
      else if (leave && !accept) cnt <= cnt - CAR_W'(1);
      if (illegal) viol <= 1'b1;
    end
  end

  assign cib = (cnt != '0);
endmodule

// File: rtl/bridge_plant_model.sv
// Drawbridge plant: deck motion FSM, position, car occupancy, boat sensor and sticky flags.
// Optional jam model enabled with `define BRIDGE_PLANT_JAM_EN.
module bridge_plant_model
  import bridge_pkg::*;
#(
  parameter int TRAVEL_TICKS = TRAVEL_TICKS_DEF,
  parameter int POS_W        = POS_W_DEF,
  parameter int CAR_W        = CAR_W_DEF
) (
  input  logic                 Clock,
  input  logic                 Reset,
  bridge_plant_model_if.slave  bus
);
  localparam logic [POS_W-1:0] POS_TOP = POS_W'(TRAVEL_TICKS);

  motion_t          state, state_n;
  logic [POS_W-1:0] pos_q, pos_n;
  logic             move, jam_q, bs_q, fault_q, cib;
  logic             unused_al;

  assign unused_al = bus.AL;

`ifdef BRIDGE_PLANT_JAM_EN
  // A jam overrides the motor: position and direction freeze until it is released.
  assign move = bus.MT & ~bus.jam_inject;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) jam_q <= 1'b0;
    else        jam_q <= bus.jam_inject;
  end
`else
  logic unused_jam;
  assign unused_jam = bus.jam_inject;
  assign move       = bus.MT;
  assign jam_q      = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= AT_LOW;
      pos_q <= '0;
    end else begin
      state <= state_n;
      pos_q <= pos_n;
    end
  end

  // Direction lives in the state; a stopped motor keeps it, so travel never reverses midway.
  always_comb begin
    state_n = state;
    pos_n   = pos_q;
    if (move) begin
      case (state)
        AT_LOW, RAISING: begin
          pos_n   = pos_q + POS_W'(1);
          state_n = (pos_n == POS_TOP) ? AT_HIGH : RAISING;
        end
        AT_HIGH, LOWERING: begin
          pos_n   = pos_q - POS_W'(1);
          state_n = (pos_n == '0) ? AT_LOW : LOWERING;
        end
        default: state_n = AT_LOW;
      endcase
    end
  end

  always_comb begin
    bus.H      = (pos_q == POS_TOP);
    bus.L      = (pos_q == '0);
    bus.pos    = pos_q;
    bus.state  = state;
    bus.jammed = jam_q;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bs_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (bus.boat_arrive)                       bs_q <= 1'b1;
      else if (bus.boat_clear && pos_q == POS_TOP) bs_q <= 1'b0;
      if (bus.MT && cib) fault_q <= 1'b1;
    end
  end

  assign bus.BS    = bs_q;
  assign bus.fault = fault_q;
  assign bus.CIB   = cib;

  bridge_car_counter #(.CAR_W(CAR_W)) u_cars (
    .clk       (Clock),
    .rst_n     (Reset),
    .car_enter (bus.car_enter),
    .car_exit  (bus.car_exit),
    .tfl       (bus.TFL),
    .low       (pos_q == '0),
    .cnt       (bus.car_cnt),
    .cib       (cib),
    .viol      (bus.viol)
  );
endmodule

// File: tb/tb_bridge_plant_model.sv
// Bench for bridge_plant_model: vector table, directed travel/boat/fault sequences,
// and randomized traffic against a position/direction reference model.
module tb_bridge_plant_model;
  import bridge_pkg::*;

  localparam int T      = 16;
  localparam int CNTMAX = 15;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  bridge_plant_model_if bus ();

  bridge_plant_model dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int m_pos, m_cnt;
  bit m_up, m_bs, m_fault, m_viol, m_jam;

  typedef struct {
    bit mt, tfl, en, ex, arr, clr;
    int e_pos, e_cnt;
    bit e_bs, e_viol, e_fault;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_state();
    if (m_pos == 0) return int'(AT_LOW);
    if (m_pos == T) return int'(AT_HIGH);
    return m_up ? int'(RAISING) : int'(LOWERING);
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".pos"},    32'(bus.pos),     32'(m_pos));
    check({tag, ".cnt"},    32'(bus.car_cnt), 32'(m_cnt));
    check({tag, ".CIB"},    32'(bus.CIB),     32'(m_cnt != 0));
    check({tag, ".BS"},     32'(bus.BS),      32'(m_bs));
    check({tag, ".H"},      32'(bus.H),       32'(m_pos == T));
    check({tag, ".L"},      32'(bus.L),       32'(m_pos == 0));
    check({tag, ".fault"},  32'(bus.fault),   32'(m_fault));
    check({tag, ".viol"},   32'(bus.viol),    32'(m_viol));
    check({tag, ".jammed"}, 32'(bus.jammed),  32'(m_jam));
    check({tag, ".state"},  32'(bus.state),   32'(exp_state()));
  endtask

  // Reference: deck turns around only at its end stops; cars gated by light and flat deck.
  task automatic model_step();
    bit jam, acc, dec;
`ifdef BRIDGE_PLANT_JAM_EN
    jam = bus.jam_inject;
`else
    jam = 1'b0;
`endif
    acc = bus.car_enter && !bus.TFL && m_pos == 0 && m_cnt != CNTMAX;
    dec = bus.car_exit && m_cnt > 0;
    if (bus.car_enter && (bus.TFL || m_pos != 0)) m_viol = 1;
    if (bus.MT && m_cnt != 0) m_fault = 1;
    if (bus.boat_arrive) m_bs = 1;
    else if (bus.boat_clear && m_pos == T) m_bs = 0;
    m_cnt = m_cnt + int'(acc) - int'(dec);
    if (bus.MT && !jam) begin
      if (m_pos == 0) m_up = 1;
      else if (m_pos == T) m_up = 0;
      m_pos = m_up ? m_pos + 1 : m_pos - 1;
    end
    m_jam = jam;
  endtask

  task automatic set_in(input bit mt, input bit tfl, input bit en, input bit ex,
                        input bit arr, input bit clr, input bit jam);
    bus.MT          = mt;
    bus.AL          = 1'($urandom_range(0, 1));
    bus.TFL         = tfl;
    bus.car_enter   = en;
    bus.car_exit    = ex;
    bus.boat_arrive = arr;
    bus.boat_clear  = clr;
    bus.jam_inject  = jam;
  endtask

  task automatic cycle();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  // Reset is asserted between edges so the async clear is observed before any clock.
  task automatic do_reset(input string tag);
    Reset = 1'b0;
    m_pos = 0; m_cnt = 0; m_up = 1; m_bs = 0; m_fault = 0; m_viol = 0; m_jam = 0;
    #2;
    check_model(tag);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge Clock);
    #1;
    do_reset("reset");

    vecs[0]  = '{0,0,1,0,0,0, 0,1, 0,0,0};
    vecs[1]  = '{0,0,1,0,0,0, 0,2, 0,0,0};
    vecs[2]  = '{0,0,1,0,1,0, 0,3, 1,0,0};
    vecs[3]  = '{0,1,1,0,0,0, 0,3, 1,1,0};
    vecs[4]  = '{0,0,0,0,0,1, 0,3, 1,1,0};
    vecs[5]  = '{0,0,1,1,0,0, 0,3, 1,1,0};
    vecs[6]  = '{0,0,0,1,0,0, 0,2, 1,1,0};
    vecs[7]  = '{0,0,0,1,0,0, 0,1, 1,1,0};
    vecs[8]  = '{1,0,0,0,0,0, 1,1, 1,1,1};
    vecs[9]  = '{0,0,0,1,0,0, 1,0, 1,1,1};
    vecs[10] = '{0,0,1,0,0,0, 1,0, 1,1,1};
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].mt, vecs[i].tfl, vecs[i].en, vecs[i].ex, vecs[i].arr, vecs[i].clr, 0);
      cycle();
      check($sformatf("vec%0d.pos", i),   32'(bus.pos),     32'(vecs[i].e_pos));
      check($sformatf("vec%0d.cnt", i),   32'(bus.car_cnt), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d.BS", i),    32'(bus.BS),      32'(vecs[i].e_bs));
      check($sformatf("vec%0d.viol", i),  32'(bus.viol),    32'(vecs[i].e_viol));
      check($sformatf("vec%0d.fault", i), 32'(bus.fault),   32'(vecs[i].e_fault));
    end

    // Reset mid-travel homes the deck and clears the sticky flags.
    do_reset("reset_mid");

    for (int i = 0; i < T; i++) begin
      set_in(1, 0, 0, 0, 0, 0, 0);
      cycle();
      check($sformatf("raise%0d.pos", i), 32'(bus.pos), 32'(i + 1));
      check($sformatf("raise%0d.L", i),   32'(bus.L),   32'(0));
      check($sformatf("raise%0d.H", i),   32'(bus.H),   32'(i == T - 1));
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle();
    check_model("held_high");

    set_in(0, 0, 0, 0, 1, 1, 0);
    cycle();
    check("boat_arrive_clear.BS", 32'(bus.BS), 32'(1));
    set_in(0, 0, 0, 0, 0, 1, 0);
    cycle();
    check("boat_clear_high.BS", 32'(bus.BS), 32'(0));

    for (int i = 0; i < 8; i++) begin set_in(1, 0, 0, 0, 0, 0, 0); cycle(); check_model("lower_a"); end
    check("lower_a.pos", 32'(bus.pos), 32'(8));
    for (int i = 0; i < 5; i++) begin set_in(0, 0, 0, 0, 0, 0, 0); cycle(); check_model("pause"); end
    check("pause.pos", 32'(bus.pos), 32'(8));
    check("pause.state", 32'(bus.state), 32'(LOWERING));
    for (int i = 0; i < 8; i++) begin set_in(1, 0, 0, 0, 0, 0, 0); cycle(); check_model("lower_b"); end
    check("lower_b.pos", 32'(bus.pos), 32'(0));
    check("lower_b.L",   32'(bus.L),   32'(1));

    do_reset("reset_max");
    for (int i = 0; i < CNTMAX + 1; i++) begin set_in(0, 0, 1, 0, 0, 0, 0); cycle(); check_model("fill"); end
    check("full.cnt",  32'(bus.car_cnt), 32'(CNTMAX));
    check("full.viol", 32'(bus.viol),    32'(0));
    set_in(1, 0, 0, 0, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("fault_sticky", 32'(bus.fault), 32'(1));
    do_reset("reset_fault");

`ifdef BRIDGE_PLANT_JAM_EN
    for (int i = 0; i < 5; i++) begin set_in(1, 0, 0, 0, 0, 0, 0); cycle(); end
    for (int i = 0; i < 4; i++) begin set_in(1, 0, 0, 0, 0, 0, 1); cycle(); check_model("jam"); end
    check("jam.pos",    32'(bus.pos),    32'(5));
    check("jam.jammed", 32'(bus.jammed), 32'(1));
    set_in(1, 0, 0, 0, 0, 0, 0);
    cycle();
    check("jam_release.pos", 32'(bus.pos), 32'(6));
    do_reset("reset_jam");
`endif

    for (int i = 0; i < 3000; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 15) == 0));
      cycle();
      check_model("rand");
      if (i == 1500) do_reset("reset_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
